dc_fifo_wr_packer: RTL and testbench

Write-side front end for dc_fifo, running entirely in the wr_clk_i domain. Accepts a narrow valid/ready stream and packs RATIO input beats into one wide FIFO word, then drives wr_data/wr_i into dc_fifo under wr_full back-pressure. The FIFO word carries a lane count and a last flag, so the read side can unpack it. Partial words are emitted on s_last, on an explicit flush, or after an idle timeout.

---
 rtl/fifo_pkg.sv | 40 ++++
 rtl/packer_idle_timer.sv | 34 +++
 rtl/dc_fifo_wr_packer.sv | 110 +++++++++++
 tb/tb_dc_fifo_wr_packer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared field layout and packing helper for dc_fifo words.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int PACK_MAX_W     = 1024;
    localparam int DEF_IN_WIDTH   = 8;
    localparam int DEF_RATIO      = 4;

    function automatic int cnt_lsb(input int ratio, input int in_width);
        return ratio * in_width;
    endfunction

    function automatic int last_bit(input int ratio, input int in_width);
        return ratio * in_width + $clog2(ratio);
    endfunction

    localparam int CNT_LSB  = cnt_lsb(DEF_RATIO, DEF_IN_WIDTH);
    localparam int LAST_BIT = last_bit(DEF_RATIO, DEF_IN_WIDTH);

    // Result is over-wide; callers truncate to their FIFO_WIDTH. Data must be
    // zero above the lane area so it does not collide with the count field.
    function automatic logic [PACK_MAX_W-1:0] pack_fields(
        input logic                  last,
        input logic [31:0]           lanes_m1,
        input logic [PACK_MAX_W-1:0] data,
        input int                    ratio,
        input int                    in_width
    );
        logic [PACK_MAX_W-1:0] w_word;
        w_word = data | (PACK_MAX_W'(lanes_m1) << cnt_lsb(ratio, in_width));
        w_word[last_bit(ratio, in_width)] = last;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packer_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : packer_idle_timer
// Description : Saturating idle counter; flags timeout while saturated.
// Revision    : 1.0 - initial release
// ============================================================================
module packer_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int             TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  C_LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (r_cnt != C_LIMIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign timeout_o = (TIMEOUT != 0) && (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/dc_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : dc_fifo_wr_packer
// Description : Packs RATIO narrow beats into one dc_fifo word with lane count.
// Revision    : 1.0 - initial release
// ============================================================================
module dc_fifo_wr_packer
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int RATIO         = 4,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int CNT_WIDTH     = $clog2(RATIO),
    parameter int FIFO_WIDTH    = RATIO * IN_WIDTH + CNT_WIDTH + 1
) (
    input  logic                  rst_i,
    input  logic                  wr_clk_i,
    input  logic [IN_WIDTH-1:0]   s_data_i,
    input  logic                  s_valid_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    input  logic                  flush_i,
    output logic [FIFO_WIDTH-1:0] wr_data_o,
    output logic                  wr_o,
    input  logic                  wr_full_i,
    output logic                  busy_o
);

    localparam int                   DATA_W    = RATIO * IN_WIDTH;
    localparam logic [CNT_WIDTH-1:0] C_LAST_LN = CNT_WIDTH'(RATIO - 1);

    logic [CNT_WIDTH-1:0]  r_lane_cnt;
    logic [DATA_W-1:0]     r_acc;
    logic                  r_out_valid;
    logic [FIFO_WIDTH-1:0] r_out_word;
    logic                  r_flush_pend;

    logic                  w_ready, w_accept, w_wr, w_lane_zero, w_timeout;
    logic                  w_flush_cmd, w_close_beat, w_close_flush, w_close, w_last;
    logic [CNT_WIDTH-1:0]  w_lanes_m1;
    logic [DATA_W-1:0]     w_acc_next;
    logic [FIFO_WIDTH-1:0] w_word_next;

    assign w_ready     = !(r_out_valid && wr_full_i);
    assign w_accept    = s_valid_i && w_ready;
    assign w_wr        = r_out_valid && !wr_full_i;
    assign w_lane_zero = (r_lane_cnt == '0);
    assign w_flush_cmd = flush_i || r_flush_pend;

    // A beat alongside a flush is packed first; a timeout never closes a word
    // on a cycle that accepted a beat, since that beat restarts the idle timer.
    assign w_close_beat  = w_accept && ((r_lane_cnt == C_LAST_LN) || s_last_i || w_flush_cmd);
    assign w_close_flush = !w_accept && !w_lane_zero && w_ready && (w_flush_cmd || w_timeout);
    assign w_close       = w_close_beat || w_close_flush;
    assign w_last        = w_close_beat && s_last_i;
    assign w_lanes_m1    = w_close_beat ? r_lane_cnt : r_lane_cnt - 1'b1;

    always_comb begin
        w_acc_next = r_acc;
        if (w_accept) begin
            w_acc_next[r_lane_cnt * IN_WIDTH +: IN_WIDTH] = s_data_i;
        end
    end

    assign w_word_next = FIFO_WIDTH'(pack_fields(w_last, 32'(w_lanes_m1),
                                                 PACK_MAX_W'(w_acc_next), RATIO, IN_WIDTH));

    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lane_cnt   <= '0;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_close) begin
                r_out_valid <= 1'b1;
                r_out_word  <= w_word_next;
                r_acc       <= '0;
                r_lane_cnt  <= '0;
            end else begin
                if (w_wr) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_acc      <= w_acc_next;
                    r_lane_cnt <= r_lane_cnt + 1'b1;
                end
            end
            // Flush requests blocked by back-pressure wait for the slot to free.
            r_flush_pend <= w_flush_cmd && !w_lane_zero && !w_ready;
        end
    end

    packer_idle_timer #(
        .TIMEOUT (FLUSH_TIMEOUT)
    ) u_idle_timer (
        .clk_i     (wr_clk_i),
        .rst_i     (rst_i),
        .clear_i   (w_accept || w_lane_zero),
        .timeout_o (w_timeout)
    );

    assign s_ready_o = w_ready;
    assign wr_o      = w_wr;
    assign wr_data_o = r_out_word;
    assign busy_o    = r_out_valid || !w_lane_zero;

endmodule
`default_nettype wire

// File: tb/tb_dc_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dc_fifo_wr_packer
// Description : Vector table, corner sequences and randomized model check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_fifo_wr_packer;

    localparam int IN_WIDTH = 8;
    localparam int RATIO    = 4;
    localparam int FT       = 16;
    localparam int FW       = 35;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [7:0]    s_data_i;
    logic          s_valid_i, s_last_i, flush_i, wr_full_i;
    logic          s_ready_o, wr_o, busy_o;
    logic [FW-1:0] wr_data_o;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_full_viol = 0;
    logic [FW-1:0] got[$];

    always #5 clk = ~clk;

    dc_fifo_wr_packer #(
        .IN_WIDTH      (IN_WIDTH),
        .RATIO         (RATIO),
        .FLUSH_TIMEOUT (FT)
    ) dut (
        .rst_i     (rst_i),
        .wr_clk_i  (clk),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_last_i  (s_last_i),
        .s_ready_o (s_ready_o),
        .flush_i   (flush_i),
        .wr_data_o (wr_data_o),
        .wr_o      (wr_o),
        .wr_full_i (wr_full_i),
        .busy_o    (busy_o)
    );

    always @(negedge clk) begin
        if (wr_o) got.push_back(wr_data_o);
        if (wr_o && wr_full_i) n_full_viol++;
    end

    typedef struct {
        logic [7:0]    d;
        logic          v, l, f;
        logic          ew;
        logic [FW-1:0] word;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(logic [7:0] d, logic v, logic l, logic f, logic ew, logic [FW-1:0] w);
        vec_t r;
        r.d = d; r.v = v; r.l = l; r.f = f; r.ew = ew; r.word = w;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [7:0] d, logic v, logic l, logic f);
        s_data_i = d; s_valid_i = v; s_last_i = l; flush_i = f;
    endtask

    // Reference model: current word as a byte queue plus one pending output word.
    logic [7:0]    m_part[$];
    bit            m_pv;
    logic [FW-1:0] m_pw;
    int            m_idle;
    bit            m_fp;

    function automatic logic [FW-1:0] model_word(logic last);
        logic [FW-1:0] w;
        w = '0;
        for (int j = 0; j < m_part.size(); j++) w[8*j +: 8] = m_part[j];
        w[33:32] = 2'(m_part.size() - 1);
        w[34]    = last;
        return w;
    endfunction

    initial begin
        int first_wr;

        rst_i = 1'b1;
        wr_full_i = 1'b0;
        drive(8'h00, 0, 0, 0);
        #2;
        chk("reset_wr",    64'(wr_o), 0);
        chk("reset_data",  64'(wr_data_o), 0);
        chk("reset_ready", 64'(s_ready_o), 1);
        chk("reset_busy",  64'(busy_o), 0);
        next_cycle();
        rst_i = 1'b0;

        // Full words, a short packet, flush with a beat, flush on empty, back-to-back.
        tbl[0]  = mk(8'h11, 1, 0, 0, 0, '0);
        tbl[1]  = mk(8'h22, 1, 0, 0, 0, '0);
        tbl[2]  = mk(8'h33, 1, 0, 0, 0, '0);
        tbl[3]  = mk(8'h44, 1, 0, 0, 0, '0);
        tbl[4]  = mk(8'h00, 0, 0, 0, 1, 35'h3_44332211);
        tbl[5]  = mk(8'h00, 0, 0, 0, 0, '0);
        tbl[6]  = mk(8'hAA, 1, 0, 0, 0, '0);
        tbl[7]  = mk(8'hBB, 1, 1, 0, 0, '0);
        tbl[8]  = mk(8'h00, 0, 0, 0, 1, 35'h5_0000BBAA);
        tbl[9]  = mk(8'h00, 0, 0, 0, 0, '0);
        tbl[10] = mk(8'h01, 1, 0, 0, 0, '0);
        tbl[11] = mk(8'h02, 1, 0, 0, 0, '0);
        tbl[12] = mk(8'h03, 1, 0, 1, 0, '0);
        tbl[13] = mk(8'h00, 0, 0, 0, 1, 35'h2_00030201);
        tbl[14] = mk(8'h00, 0, 0, 1, 0, '0);
        tbl[15] = mk(8'h00, 0, 0, 0, 0, '0);
        tbl[16] = mk(8'h00, 0, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) tbl[17+i] = mk(8'(8'h10 + i), 1, 0, 0, 0, '0);
        tbl[21].ew = 1; tbl[21].word = 35'h3_13121110;
        tbl[25] = mk(8'h00, 0, 0, 0, 1, 35'h3_17161514);
        tbl[26] = mk(8'h00, 0, 0, 0, 0, '0);

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].f);
            @(negedge clk);
            chk($sformatf("tbl%0d_wr", i), 64'(wr_o), 64'(tbl[i].ew));
            chk($sformatf("tbl%0d_ready", i), 64'(s_ready_o), 1);
            if (tbl[i].ew) chk($sformatf("tbl%0d_data", i), 64'(wr_data_o), 64'(tbl[i].word));
            next_cycle();
        end

        // Back-pressure: one word stuck behind wr_full_i, the next beat stalls.
        got.delete();
        wr_full_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(8'(8'h21 + i), 1, 0, 0);
            next_cycle();
        end
        drive(8'h25, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("full_ready", 64'(s_ready_o), 0);
            chk("full_nowr", 64'(wr_o), 0);
            next_cycle();
        end
        wr_full_i = 1'b0;
        @(negedge clk);
        chk("release_wr", 64'(wr_o), 1);
        chk("release_ready", 64'(s_ready_o), 1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(8'(8'h26 + i), 1, 0, 0);
            next_cycle();
        end
        drive(8'h00, 0, 0, 0);
        repeat (3) next_cycle();
        chk("bp_count", 64'(got.size()), 2);
        if (got.size() == 2) begin
            chk("bp_word0", 64'(got[0]), 64'(35'h3_24232221));
            chk("bp_word1", 64'(got[1]), 64'(35'h3_28272625));
        end

        // Timeout: idle counts 0..16 after the beat's edge, so the write lands
        // 17 cycles after the slot a closing beat would have used (k = 18).
        got.delete();
        first_wr = 0;
        drive(8'h5A, 1, 0, 0);
        next_cycle();
        drive(8'h00, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (wr_o && first_wr == 0) first_wr = k;
            next_cycle();
        end
        chk("timeout_cycle", 64'(first_wr), 18);
        chk("timeout_count", 64'(got.size()), 1);
        if (got.size() == 1) chk("timeout_word", 64'(got[0]), 64'(35'h0_0000005A));

        // Asynchronous reset mid-word.
        drive(8'h01, 1, 0, 0);
        next_cycle();
        drive(8'h02, 1, 0, 0);
        next_cycle();
        drive(8'h00, 0, 0, 0);
        chk("pre_rst_busy", 64'(busy_o), 1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_wr",    64'(wr_o), 0);
        chk("rst_data",  64'(wr_data_o), 0);
        chk("rst_ready", 64'(s_ready_o), 1);
        chk("rst_busy",  64'(busy_o), 0);
        next_cycle();
        rst_i = 1'b0;
        got.delete();
        repeat (30) next_cycle();
        chk("rst_nowr", 64'(got.size()), 0);

        // Randomized traffic against the reference model.
        m_part.delete(); m_pv = 0; m_pw = '0; m_idle = 0; m_fp = 0;
        for (int c = 0; c < 3000; c++) begin
            bit            rdy, mwr, acc, to, fc, closed, lst;
            int            n0;
            logic [7:0]    d;
            logic          v, l, f;
            if ((c % 500) >= 470) begin
                v = 0; l = 0; f = 0; d = 8'h00;
                wr_full_i = 1'b0;
            end else begin
                d = 8'($urandom);
                v = ($urandom_range(0, 9) < 7);
                l = ($urandom_range(0, 9) == 0);
                f = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 9) == 0) wr_full_i = ~wr_full_i;
            end
            drive(d, v, l, f);
            @(negedge clk);
            rdy = !(m_pv && wr_full_i);
            mwr = m_pv && !wr_full_i;
            chk("rnd_ready", 64'(s_ready_o), 64'(rdy));
            chk("rnd_wr", 64'(wr_o), 64'(mwr));
            chk("rnd_busy", 64'(busy_o), 64'(m_pv || m_part.size() != 0));
            if (mwr) chk("rnd_data", 64'(wr_data_o), 64'(m_pw));
            n0 = m_part.size();
            acc = v && rdy;
            to = (m_idle == FT);
            fc = f || m_fp;
            closed = 0;
            lst = 0;
            if (acc) begin
                m_part.push_back(d);
                if (m_part.size() == RATIO || l || fc) begin
                    closed = 1;
                    lst = l;
                end
            end else if (n0 > 0 && rdy && (fc || to)) begin
                closed = 1;
            end
            if (closed) begin
                m_pw = model_word(lst);
                m_part.delete();
                m_pv = 1;
            end else if (mwr) begin
                m_pv = 0;
            end
            m_fp = fc && n0 != 0 && !rdy;
            m_idle = (acc || n0 == 0) ? 0 : ((m_idle < FT) ? m_idle + 1 : FT);
            next_cycle();
        end

        chk("no_write_while_full", 64'(n_full_viol), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
